// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-style control FSM.
// Build option: MC_JAL_EN adds the JAL state and opcode 000011 support.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_ADDI_EX  = 4'd8,
    S_ADDI_WB  = 4'd9,
    S_BEQ      = 4'd10,
    S_BNE      = 4'd11,
    S_JUMP     = 4'd12
`ifdef MC_JAL_EN
    , S_JAL    = 4'd13
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b10;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: opcode in, strobes and mux selects out.
interface mc_if;
  logic [5:0] opcode;
  logic       ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite;
  logic       PCWrite, PCWriteCondbeq, PCWriteCondbne;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, regdst, memtoreg;
  logic       illegal_op;

  modport master (
    input  opcode,
    output ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite,
           PCWrite, PCWriteCondbeq, PCWriteCondbne,
           PCSrc, ALUSrcB, ALUOp, regdst, memtoreg, illegal_op
  );

  modport slave (
    output opcode,
    input  ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite,
           PCWrite, PCWriteCondbeq, PCWriteCondbne,
           PCSrc, ALUSrcB, ALUOp, regdst, memtoreg, illegal_op
  );
endinterface

// File: rtl/mc_controller.sv
// Moore control FSM for a multicycle MIPS-subset datapath.
// Build option: MC_JAL_EN enables the JAL state; otherwise 000011 is illegal.
module mc_controller
  import mc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  mc_if.master   bus
);

  state_t state, state_nxt;
  logic   illegal_q, illegal_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      illegal_q <= illegal_nxt;
    end
  end

  // opcode is only looked at in DECODE and MEMADR
  always_comb begin
    state_nxt   = S_FETCH;
    illegal_nxt = illegal_q;
    case (state)
      S_FETCH:    state_nxt = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_RTYPE_EX;
          OP_ADDI:      state_nxt = S_ADDI_EX;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_BNE:       state_nxt = S_BNE;
          OP_J:         state_nxt = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:       state_nxt = S_JAL;
`endif
          default: begin
            state_nxt   = S_FETCH;
            illegal_nxt = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_nxt = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = S_MEMWB;
      S_RTYPE_EX: state_nxt = S_RTYPE_WB;
      S_ADDI_EX:  state_nxt = S_ADDI_WB;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    bus.ALUSrcA        = 1'b0;
    bus.memread        = 1'b0;
    bus.memwrite       = 1'b0;
    bus.regwrite       = 1'b0;
    bus.IorD           = 1'b0;
    bus.IRWrite        = 1'b0;
    bus.PCWrite        = 1'b0;
    bus.PCWriteCondbeq = 1'b0;
    bus.PCWriteCondbne = 1'b0;
    bus.PCSrc          = PCSRC_ALU;
    bus.ALUSrcB        = SRCB_B;
    bus.ALUOp          = ALUOP_ADD;
    bus.regdst         = REGDST_RT;
    bus.memtoreg       = M2R_ALUOUT;
    case (state)
      S_FETCH: begin
        bus.memread = 1'b1;
        bus.IRWrite = 1'b1;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
      end
      S_DECODE: bus.ALUSrcB = SRCB_IMM_SL2;
      S_MEMADR, S_ADDI_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.IorD    = 1'b1;
        bus.memread = 1'b1;
      end
      S_MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = M2R_MDR;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_RTYPE_EX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = REGDST_RD;
      end
      S_ADDI_WB: bus.regwrite = 1'b1;
      S_BEQ, S_BNE: begin
        bus.ALUSrcA        = 1'b1;
        bus.ALUOp          = ALUOP_SUB;
        bus.PCSrc          = PCSRC_ALUOUT;
        bus.PCWriteCondbeq = (state == S_BEQ);
        bus.PCWriteCondbne = (state == S_BNE);
      end
      S_JUMP: begin
        bus.PCSrc   = PCSRC_JUMP;
        bus.PCWrite = 1'b1;
      end
`ifdef MC_JAL_EN
      // PC already holds PC+4 here, so r31 gets the return address
      S_JAL: begin
        bus.PCSrc    = PCSRC_JUMP;
        bus.PCWrite  = 1'b1;
        bus.regwrite = 1'b1;
        bus.regdst   = REGDST_R31;
        bus.memtoreg = M2R_PC;
      end
`endif
      default: ;
    endcase
  end

  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller; output vectors are hand-written per state.
module tb_mc_controller;

  logic clk;
  logic rst;
  mc_if bus ();

  mc_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // {ALUSrcA,memread,memwrite,regwrite,IorD,IRWrite,PCWrite,CondBeq,CondBne, PCSrc,ALUSrcB,ALUOp,regdst,memtoreg}
  localparam logic [18:0] E_FETCH  = {9'b010001100, 10'b00_01_00_00_00};
  localparam logic [18:0] E_DECODE = {9'b000000000, 10'b00_11_00_00_00};
  localparam logic [18:0] E_MEMADR = {9'b100000000, 10'b00_10_00_00_00};
  localparam logic [18:0] E_MEMRD  = {9'b010010000, 10'b00_00_00_00_00};
  localparam logic [18:0] E_MEMWB  = {9'b000100000, 10'b00_00_00_00_01};
  localparam logic [18:0] E_MEMWR  = {9'b001010000, 10'b00_00_00_00_00};
  localparam logic [18:0] E_RTEX   = {9'b100000000, 10'b00_00_10_00_00};
  localparam logic [18:0] E_RTWB   = {9'b000100000, 10'b00_00_00_01_00};
  localparam logic [18:0] E_ADDIEX = {9'b100000000, 10'b00_10_00_00_00};
  localparam logic [18:0] E_ADDIWB = {9'b000100000, 10'b00_00_00_00_00};
  localparam logic [18:0] E_BEQ    = {9'b100000010, 10'b10_00_01_00_00};
  localparam logic [18:0] E_BNE    = {9'b100000001, 10'b10_00_01_00_00};
  localparam logic [18:0] E_JUMP   = {9'b000000100, 10'b01_00_00_00_00};
  localparam logic [18:0] E_JAL    = {9'b000100100, 10'b01_00_00_10_10};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [18:0] exp);
    logic [18:0] obs;
    obs = {bus.ALUSrcA, bus.memread, bus.memwrite, bus.regwrite, bus.IorD,
           bus.IRWrite, bus.PCWrite, bus.PCWriteCondbeq, bus.PCWriteCondbne,
           bus.PCSrc, bus.ALUSrcB, bus.ALUOp, bus.regdst, bus.memtoreg};
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_ill(input string tag, input logic exp);
    n_cmp++;
    assert (bus.illegal_op === exp) else begin
      n_mis++;
      $error("FAIL %s: observed illegal_op=%b expected %b", tag, bus.illegal_op, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = 6'b111111;
    #3;
    chk("reset_fetch", E_FETCH);
    chk_ill("reset_ill", 1'b0);
    tick();
    chk("reset_hold", E_FETCH);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_fetch", E_FETCH);

    // lw: 5 cycles; opcode is noise in FETCH and in MEMRD/MEMWB
    tick(); bus.opcode = 6'b100011; chk("lw_decode", E_DECODE);
    tick(); chk("lw_memadr", E_MEMADR);
    tick(); bus.opcode = 6'b111111; chk("lw_memrd", E_MEMRD);
    tick(); chk("lw_memwb", E_MEMWB);
    tick(); chk("lw_fetch", E_FETCH);
    chk_ill("lw_no_ill", 1'b0);

    // beq then bne: 3 cycles each
    tick(); bus.opcode = 6'b000100; chk("beq_decode", E_DECODE);
    tick(); chk("beq_state", E_BEQ);
    tick(); chk("beq_fetch", E_FETCH);
    tick(); bus.opcode = 6'b000101; chk("bne_decode", E_DECODE);
    tick(); chk("bne_state", E_BNE);
    tick(); chk("bne_fetch", E_FETCH);

    // R-type then sw: 4 cycles each
    tick(); bus.opcode = 6'b000000; chk("rt_decode", E_DECODE);
    tick(); chk("rt_ex", E_RTEX);
    tick(); chk("rt_wb", E_RTWB);
    tick(); chk("rt_fetch", E_FETCH);
    tick(); bus.opcode = 6'b101011; chk("sw_decode", E_DECODE);
    tick(); chk("sw_memadr", E_MEMADR);
    tick(); bus.opcode = 6'b100011; chk("sw_memwr", E_MEMWR);
    tick(); chk("sw_fetch", E_FETCH);

    // addi and j
    tick(); bus.opcode = 6'b001000; chk("addi_decode", E_DECODE);
    tick(); chk("addi_ex", E_ADDIEX);
    tick(); chk("addi_wb", E_ADDIWB);
    tick(); chk("addi_fetch", E_FETCH);
    tick(); bus.opcode = 6'b000010; chk("j_decode", E_DECODE);
    tick(); chk("j_state", E_JUMP);
    tick(); chk("j_fetch", E_FETCH);
    chk_ill("legal_no_ill", 1'b0);

`ifdef MC_JAL_EN
    tick(); bus.opcode = 6'b000011; chk("jal_decode", E_DECODE);
    tick(); chk("jal_state", E_JAL);
    tick(); chk("jal_fetch", E_FETCH);
    chk_ill("jal_no_ill", 1'b0);
`else
    tick(); bus.opcode = 6'b000011; chk("jal_decode", E_DECODE);
    chk_ill("jal_ill_in_decode", 1'b0);
    tick(); chk("jal_illegal_fetch", E_FETCH);
    chk_ill("jal_ill_set", 1'b1);
    rst = 1'b1;
    #2;
    chk_ill("jal_ill_cleared", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("jal_post_reset", E_FETCH);
`endif

    // 111111: illegal, sticky across a following legal addi
    tick(); bus.opcode = 6'b111111; chk("ill_decode", E_DECODE);
    chk_ill("ill_low_in_decode", 1'b0);
    tick(); chk("ill_fetch", E_FETCH);
    chk_ill("ill_set", 1'b1);
    tick(); bus.opcode = 6'b001000; chk("ill_addi_decode", E_DECODE);
    tick(); chk("ill_addi_ex", E_ADDIEX);
    tick(); chk("ill_addi_wb", E_ADDIWB);
    tick(); chk("ill_addi_fetch", E_FETCH);
    chk_ill("ill_sticky", 1'b1);

    // reset mid-MEMRD aborts the load before writeback
    tick(); bus.opcode = 6'b100011; chk("abort_decode", E_DECODE);
    tick(); chk("abort_memadr", E_MEMADR);
    tick(); chk("abort_memrd", E_MEMRD);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_fetch_async", E_FETCH);
    chk_ill("abort_ill_clear", 1'b0);
    tick(); chk("abort_no_wb", E_FETCH);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_release_fetch", E_FETCH);
    tick(); bus.opcode = 6'b000010; chk("final_decode", E_DECODE);
    tick(); chk("final_jump", E_JUMP);
    tick(); chk("final_fetch", E_FETCH);
    chk_ill("final_ill", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset. Ports are clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 opcode  input  6  inst[31:26] from the datapath IR; valid from the DECODE cycle onward.
REQ-005 ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite, PCWrite, PCWriteCondbeq, PCWriteCondbne  output  1 each  datapath strobes and selects.
REQ-006 PCSrc, ALUSrcB, ALUOp, regdst, memtoreg  output  2 each  datapath mux selects.
- PCSrc: 00 ALUResult, 01 jump, 10 ALUOut.
- ALUSrcB: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm << 2.
- ALUOp: 00 add, 01 sub, 10 funct-decoded.
- regdst: 00 rt, 01 rd, 10 r31.
- memtoreg: 00 ALUOut, 01 MDR, 10 PC.
REQ-007 illegal_op  output  1  sticky flag; set when an unsupported opcode is decoded.

Function
REQ-008 The FSM SHALL be Moore: every output is a pure function of the current state, and each output is 0 (or 2'b00) unless the state lists it.
REQ-009 FETCH SHALL drive: memread=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1. Next state: DECODE.
REQ-010 DECODE SHALL drive: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
- 100011 lw or 101011 sw -> MEMADR
- 000000 -> RTYPE_EX
- 001000 -> ADDI_EX
- 000100 -> BEQ
- 000101 -> BNE
- 000010 -> JUMP
- 000011 -> JAL
- any other -> FETCH, and set illegal_op.
REQ-011 MEMADR SHALL drive: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD for lw, MEMWR for sw.
REQ-012 MEMRD SHALL drive: IorD=1, memread=1. Next state: MEMWB.
REQ-013 MEMWB SHALL drive: regwrite=1, regdst=00, memtoreg=01. Next state: FETCH.
REQ-014 MEMWR SHALL drive: IorD=1, memwrite=1. Next state: FETCH.
REQ-015 RTYPE_EX SHALL drive: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: RTYPE_WB.
REQ-016 RTYPE_WB SHALL drive: regwrite=1, regdst=01, memtoreg=00. Next state: FETCH.
REQ-017 ADDI_EX SHALL drive: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: ADDI_WB.
REQ-018 ADDI_WB SHALL drive: regwrite=1, regdst=00, memtoreg=00. Next state: FETCH.
REQ-019 BEQ SHALL drive: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=10, PCWriteCondbeq=1. Next state: FETCH.
REQ-020 BNE SHALL drive the same outputs as BEQ, except PCWriteCondbne=1 instead of PCWriteCondbeq=1. Next state: FETCH.
REQ-021 JUMP SHALL drive: PCSrc=01, PCWrite=1. Next state: FETCH.
REQ-022 JAL SHALL drive: PCSrc=01, PCWrite=1, regwrite=1, regdst=10, memtoreg=10. Next state: FETCH.
- PC holds PC+4 during this cycle, so r31 receives PC+4.
REQ-023 Instruction latency SHALL be, in cycles from FETCH entry to the next FETCH: lw 5; sw, R-type and addi 4; beq, bne, j and jal 3; illegal 2.
REQ-024 opcode SHALL be sampled only in DECODE and MEMADR; opcode changes in any other state SHALL have no effect.
REQ-025 The state register SHALL never hold an unencoded value. Any unreachable encoding SHALL go to FETCH on the next edge.

Reset
REQ-026 While rst=1, the state SHALL be FETCH and illegal_op SHALL be 0, asynchronously.
REQ-027 Outputs SHALL therefore equal the FETCH values during reset. The datapath PC is gated by its own reset.
REQ-028 Reset asserted mid-instruction SHALL abort it; no partial writeback SHALL occur after rst rises.
REQ-029 The first cycle after rst falls SHALL be a FETCH cycle.

Configuration
REQ-030 With macro MC_JAL_EN defined, the JAL state and opcode 000011 SHALL be supported as in REQ-010 and REQ-022.
REQ-031 Without MC_JAL_EN, the JAL state SHALL not exist, and opcode 000011 SHALL be handled as illegal.
- Outputs regdst=10 and memtoreg=10 are then never driven.

Structure
REQ-032 Package mc_pkg SHALL hold:
- the state enum;
- opcode localparams;
- encodings for ALUOp, ALUSrcB, PCSrc, regdst and memtoreg.
REQ-033 No sub-module is required. The block is a single module with a state register, a next-state block and an output decode block.

Verification
REQ-034 Bench scenarios (stimulus -> required response):
- rst pulse mid-MEMRD -> state is FETCH immediately, regwrite=0, illegal_op=0.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 only in cycle 5, with memtoreg=01.
- beq (000100) then bne (000101) -> 3 cycles each; PCWriteCondbeq=1 only in BEQ, PCWriteCondbne=1 only in BNE, PCSrc=10 in both.
- R-type (000000) followed by sw (101011) -> 4 and 4 cycles; memwrite=1 only in MEMWR, with IorD=1.
- jal (000011) with MC_JAL_EN -> regdst=10, memtoreg=10, PCWrite=1 in cycle 3. Without MC_JAL_EN -> back to FETCH after DECODE, and illegal_op=1.
- Opcode 111111 -> illegal_op rises at the end of DECODE and stays 1 across later legal instructions until rst.
